// File: rtl/id_fwd_stage.sv
// id_fwd_stage: decode/operand-fetch stage of the 16-bit pipelined core.
// Selects operands for the instruction in ID, forwards results from EX/MEM/WB,
// inserts a one-cycle bubble on a load-use hazard and honours branch flushes.
module id_fwd_stage #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [15:0]           id_ir,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [15:0]           mem_ir,
  input  logic [15:0]           wb_ir,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic [DATA_W-1:0]     mem_result,
  input  logic [DATA_W-1:0]     wb_result,
  input  logic [8*DATA_W-1:0]   rf_rdata,
  output logic [15:0]           ex_ir,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     reg_A,
  output logic [DATA_W-1:0]     reg_B,
  output logic [DATA_W-1:0]     smdr,
  output logic [CNT_W-1:0]      stall_cnt
);

  // Opcode map of the core's instruction set
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  // reg_B source kinds
  localparam logic [2:0] B_NONE  = 3'd0;
  localparam logic [2:0] B_IMM4  = 3'd1;
  localparam logic [2:0] B_IMMHI = 3'd2;
  localparam logic [2:0] B_IMM8  = 3'd3;
  localparam logic [2:0] B_R3    = 3'd4;

  // True for opcodes that write r1 with an ALU result
  function automatic logic is_aluw(input logic [4:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC,
      OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Newest in-flight value of register s, EX first, then MEM, WB, file
  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic [2:0]        s,
    input logic              ex_wr,
    input logic [2:0]        ex_dst,
    input logic              mem_wr,
    input logic [2:0]        mem_dst,
    input logic              wb_wr,
    input logic [2:0]        wb_dst,
    input logic [DATA_W-1:0] ex_val,
    input logic [DATA_W-1:0] mem_val,
    input logic [DATA_W-1:0] wb_val,
    input logic [DATA_W-1:0] rf_val
  );
    logic [DATA_W-1:0] v;
    if (ex_wr && ex_dst == s)        v = ex_val;
    else if (mem_wr && mem_dst == s) v = mem_val;
    else if (wb_wr && wb_dst == s)   v = wb_val;
    else                             v = rf_val;
    return v;
  endfunction

  logic [DATA_W-1:0] gr [8];
  logic [4:0]        id_op;
  logic [2:0]        id_r1, id_r2, id_r3;
  logic              use_a, a_from_r1, use_smdr, use_b;
  logic [2:0]        b_sel;
  logic [2:0]        src_a;
  logic              ex_wr, mem_wr, wb_wr;
  logic              stall;
  logic [DATA_W-1:0] fwd_a, fwd_b, fwd_s, b_next;
  logic              unused_ir_bits;

  for (genvar i = 0; i < 8; i++) begin : g_gr
    assign gr[i] = rf_rdata[i*DATA_W +: DATA_W];
  end

  assign id_op = id_ir[15:11];
  assign id_r1 = id_ir[10:8];
  assign id_r2 = id_ir[6:4];
  assign id_r3 = id_ir[2:0];

  // Low bytes of the MEM/WB IRs carry nothing this stage needs
  assign unused_ir_bits = ^{mem_ir[7:0], wb_ir[7:0]};

  // Decode which operands the ID instruction reads and where reg_B comes from
  always_comb begin
    use_a     = 1'b0;
    a_from_r1 = 1'b0;
    use_smdr  = 1'b0;
    b_sel     = B_NONE;
    case (id_op)
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC, OP_JMPR, OP_ADDI, OP_SUBI: begin
        use_a     = 1'b1;
        a_from_r1 = 1'b1;
        b_sel     = B_IMM8;
      end
      OP_LDIH: begin
        use_a     = 1'b1;
        a_from_r1 = 1'b1;
        b_sel     = B_IMMHI;
      end
      OP_LOAD, OP_SLL, OP_SRL, OP_SLA, OP_SRA: begin
        use_a = 1'b1;
        b_sel = B_IMM4;
      end
      OP_STORE: begin
        use_a    = 1'b1;
        use_smdr = 1'b1;
        b_sel    = B_IMM4;
      end
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR: begin
        use_a = 1'b1;
        b_sel = B_R3;
      end
      default: begin
        use_a = 1'b0;
      end
    endcase
  end

  assign src_a  = a_from_r1 ? id_r1 : id_r2;
  assign use_b  = (b_sel != B_NONE);
  assign ex_wr  = ex_valid && is_aluw(ex_ir[15:11]);
  assign mem_wr = is_aluw(mem_ir[15:11]) || (mem_ir[15:11] == OP_LOAD);
  assign wb_wr  = is_aluw(wb_ir[15:11])  || (wb_ir[15:11] == OP_LOAD);

  // A LOAD in EX whose destination is read by ID cannot be forwarded yet
  assign stall = id_valid && ex_valid && (ex_ir[15:11] == OP_LOAD) &&
                 ((use_a && ex_ir[10:8] == src_a) ||
                  (b_sel == B_R3 && ex_ir[10:8] == id_r3) ||
                  (use_smdr && ex_ir[10:8] == id_r1));

  assign id_ready = !stall || flush;

  // Resolve forwarded register values and the reg_B immediate forms
  always_comb begin
    fwd_a = fwd_pick(src_a, ex_wr, ex_ir[10:8], mem_wr, mem_ir[10:8], wb_wr, wb_ir[10:8],
                     alu_out, mem_result, wb_result, gr[src_a]);
    fwd_b = fwd_pick(id_r3, ex_wr, ex_ir[10:8], mem_wr, mem_ir[10:8], wb_wr, wb_ir[10:8],
                     alu_out, mem_result, wb_result, gr[id_r3]);
    fwd_s = fwd_pick(id_r1, ex_wr, ex_ir[10:8], mem_wr, mem_ir[10:8], wb_wr, wb_ir[10:8],
                     alu_out, mem_result, wb_result, gr[id_r1]);
    b_next = '0;
    case (b_sel)
      B_IMM4:  b_next[3:0]  = id_ir[3:0];
      B_IMMHI: b_next[15:0] = {id_ir[7:0], 8'h00};
      B_IMM8:  b_next[7:0]  = id_ir[7:0];
      B_R3:    b_next       = fwd_b;
      default: b_next       = '0;
    endcase
  end

  // Pipeline register update: reset, hold, flush, bubble, issue, idle
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_ir     <= '0;
      ex_valid  <= 1'b0;
      reg_A     <= '0;
      reg_B     <= '0;
      smdr      <= '0;
      stall_cnt <= '0;
    end else if (enable) begin
      if (flush) begin
        ex_ir    <= '0;
        ex_valid <= 1'b0;
      end else if (stall) begin
        ex_ir    <= '0;
        ex_valid <= 1'b0;
        if (stall_cnt != {CNT_W{1'b1}})
          stall_cnt <= stall_cnt + CNT_W'(1);
      end else if (id_valid) begin
        ex_valid <= 1'b1;
        ex_ir    <= (id_op == OP_JUMP) ? 16'h0000 : id_ir;
        if (use_a)
          reg_A <= fwd_a;
        if (use_b)
          reg_B <= b_next;
        if (use_smdr)
          smdr <= fwd_s;
      end else begin
        ex_ir    <= '0;
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed testbench for id_fwd_stage: a 16-bit instance (4-bit stall counter)
// and a 32-bit instance driven in lockstep with the same instruction stream.
module tb_id_fwd_stage;

  localparam logic [4:0] NOP   = 5'b00000;
  localparam logic [4:0] LOAD  = 5'b00010;
  localparam logic [4:0] STORE = 5'b00011;
  localparam logic [4:0] SLL   = 5'b00100;
  localparam logic [4:0] ADD   = 5'b01000;
  localparam logic [4:0] ADDI  = 5'b01001;
  localparam logic [4:0] SUB   = 5'b01010;
  localparam logic [4:0] LDIH  = 5'b10000;
  localparam logic [4:0] JUMP  = 5'b11000;

  typedef struct {
    string       name;
    logic [15:0] ir;
    logic        valid, fl, en;
    logic [15:0] mir, wir, alu, mres, wres;
    logic        exp_ready;
    logic [15:0] exp_ex_ir;
    logic        exp_ex_valid;
    logic [15:0] exp_a, exp_b, exp_s;
    logic [3:0]  exp_cnt;
  } vec_t;

  logic clock, reset, enable, flush, id_valid;
  logic [15:0] id_ir, mem_ir, wb_ir;
  logic [15:0] alu16, mres16, wres16;
  logic [31:0] alu32, mres32, wres32;
  logic [8*16-1:0] rf16;
  logic [8*32-1:0] rf32;

  logic        ready16, exv16;
  logic [15:0] exir16, a16, b16, s16;
  logic [3:0]  cnt16;
  logic        ready32, exv32;
  logic [15:0] exir32;
  logic [31:0] a32, b32, s32;
  logic [15:0] cnt32;

  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  id_fwd_stage #(.DATA_W(16), .CNT_W(4)) u16 (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush),
    .id_ir(id_ir), .id_valid(id_valid), .id_ready(ready16),
    .mem_ir(mem_ir), .wb_ir(wb_ir),
    .alu_out(alu16), .mem_result(mres16), .wb_result(wres16), .rf_rdata(rf16),
    .ex_ir(exir16), .ex_valid(exv16), .reg_A(a16), .reg_B(b16), .smdr(s16),
    .stall_cnt(cnt16)
  );

  id_fwd_stage #(.DATA_W(32), .CNT_W(16)) u32 (
    .clock(clock), .reset(reset), .enable(enable), .flush(flush),
    .id_ir(id_ir), .id_valid(id_valid), .id_ready(ready32),
    .mem_ir(mem_ir), .wb_ir(wb_ir),
    .alu_out(alu32), .mem_result(mres32), .wb_result(wres32), .rf_rdata(rf32),
    .ex_ir(exir32), .ex_valid(exv32), .reg_A(a32), .reg_B(b32), .smdr(s32),
    .stall_cnt(cnt32)
  );

  // Free-running clock, period 10
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] encR(input logic [4:0] op, input logic [2:0] r1,
                                       input logic [2:0] r2, input logic [2:0] r3);
    return {op, r1, 1'b0, r2, 1'b0, r3};
  endfunction

  function automatic logic [15:0] encI8(input logic [4:0] op, input logic [2:0] r1,
                                        input logic [7:0] imm);
    return {op, r1, imm};
  endfunction

  function automatic logic [15:0] encI4(input logic [4:0] op, input logic [2:0] r1,
                                        input logic [2:0] r2, input logic [3:0] imm);
    return {op, r1, 1'b0, r2, imm};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic [15:0] ir, input logic valid,
                        input logic fl, input logic en, input logic [15:0] mir,
                        input logic [15:0] wir, input logic [15:0] alu, input logic [15:0] mres,
                        input logic [15:0] wres, input logic exp_ready, input logic [15:0] exp_ex_ir,
                        input logic exp_ex_valid, input logic [15:0] exp_a, input logic [15:0] exp_b,
                        input logic [15:0] exp_s, input logic [3:0] exp_cnt);
    vec_t v;
    v.name = name; v.ir = ir; v.valid = valid; v.fl = fl; v.en = en;
    v.mir = mir; v.wir = wir; v.alu = alu; v.mres = mres; v.wres = wres;
    v.exp_ready = exp_ready; v.exp_ex_ir = exp_ex_ir; v.exp_ex_valid = exp_ex_valid;
    v.exp_a = exp_a; v.exp_b = exp_b; v.exp_s = exp_s; v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endtask

  // Drive all inputs at the falling edge; 32-bit data mirrors the 16-bit data
  task automatic drive(input logic [15:0] ir, input logic valid, input logic fl,
                       input logic en, input logic [15:0] mir, input logic [15:0] wir,
                       input logic [15:0] alu, input logic [15:0] mres, input logic [15:0] wres);
    @(negedge clock);
    id_ir = ir; id_valid = valid; flush = fl; enable = en;
    mem_ir = mir; wb_ir = wir;
    alu16 = alu; mres16 = mres; wres16 = wres;
    alu32 = {16'h0, alu}; mres32 = {16'h0, mres}; wres32 = {16'h0, wres};
    #1;
  endtask

  task automatic clockEdge;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.ir, v.valid, v.fl, v.en, v.mir, v.wir, v.alu, v.mres, v.wres);
    checkOutput({v.name, ".id_ready"}, {31'h0, ready16}, {31'h0, v.exp_ready});
    clockEdge();
    checkOutput({v.name, ".ex_ir"},    {16'h0, exir16}, {16'h0, v.exp_ex_ir});
    checkOutput({v.name, ".ex_valid"}, {31'h0, exv16},  {31'h0, v.exp_ex_valid});
    checkOutput({v.name, ".reg_A"},    {16'h0, a16},    {16'h0, v.exp_a});
    checkOutput({v.name, ".reg_B"},    {16'h0, b16},    {16'h0, v.exp_b});
    checkOutput({v.name, ".smdr"},     {16'h0, s16},    {16'h0, v.exp_s});
    checkOutput({v.name, ".stall_cnt"},{28'h0, cnt16},  {28'h0, v.exp_cnt});
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rf16[i*16 +: 16] = 16'hA000 + 16'(i) * 16'h0011;
      rf32[i*32 +: 32] = 32'h5000_0000 + 32'(i) * 32'h0000_0101;
    end
    reset = 1'b1; enable = 1'b1; flush = 1'b0; id_valid = 1'b0;
    id_ir = 16'h0; mem_ir = 16'h0; wb_ir = 16'h0;
    alu16 = '0; mres16 = '0; wres16 = '0; alu32 = '0; mres32 = '0; wres32 = '0;

    // Table: name, ir, valid, flush, en, mem_ir, wb_ir, alu, mres, wres,
    //        ready, ex_ir, ex_valid, A, B, smdr, cnt
    addVec("add_issue",  encR(ADD,1,2,3), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0,
           1, encR(ADD,1,2,3), 1, 16'hA022, 16'hA033, 16'h0000, 4'd0);
    addVec("sub_fwd_ex", encR(SUB,4,1,5), 1,0,1, 16'h0,16'h0, 16'h1234,16'h0,16'h0,
           1, encR(SUB,4,1,5), 1, 16'h1234, 16'hA055, 16'h0000, 4'd0);
    addVec("load_issue", encI4(LOAD,2,3,4'h4), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0,
           1, encI4(LOAD,2,3,4'h4), 1, 16'hA033, 16'h0004, 16'h0000, 4'd0);
    addVec("load_use",   encR(ADD,3,2,1), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0,
           0, 16'h0000, 0, 16'hA033, 16'h0004, 16'h0000, 4'd1);
    addVec("load_fwd_mem", encR(ADD,3,2,1), 1,0,1, encI4(LOAD,2,3,4'h4),16'h0, 16'h0,16'hBEEF,16'h0,
           1, encR(ADD,3,2,1), 1, 16'hBEEF, 16'hA011, 16'h0000, 4'd1);
    addVec("flush_addi", encI8(ADDI,1,8'h05), 1,1,1, 16'h0,16'h0, 16'h0,16'h0,16'h0,
           1, 16'h0000, 0, 16'hBEEF, 16'hA011, 16'h0000, 4'd1);
    addVec("load2_issue", encI4(LOAD,5,6,4'h1), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0,
           1, encI4(LOAD,5,6,4'h1), 1, 16'hA066, 16'h0001, 16'h0000, 4'd1);
    addVec("flush_on_stall", encI4(STORE,5,0,4'h2), 1,1,1, 16'h0,16'h0, 16'h0,16'h0,16'h0,
           1, 16'h0000, 0, 16'hA066, 16'h0001, 16'h0000, 4'd1);
    addVec("store_fwd", encI4(STORE,5,0,4'h2), 1,0,1, encI8(ADDI,0,8'h00), encR(ADD,5,0,0),
           16'h0, 16'h0F0F, 16'h5A5A,
           1, encI4(STORE,5,0,4'h2), 1, 16'h0F0F, 16'h0002, 16'h5A5A, 4'd1);
    addVec("addi_issue", encI8(ADDI,7,8'h33), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0,
           1, encI8(ADDI,7,8'h33), 1, 16'hA077, 16'h0033, 16'h5A5A, 4'd1);
    addVec("prio_ex", encR(ADD,2,7,7), 1,0,1, encR(ADD,7,0,0), encI4(LOAD,7,0,4'h0),
           16'h1111, 16'h2222, 16'h3333,
           1, encR(ADD,2,7,7), 1, 16'h1111, 16'h1111, 16'h5A5A, 4'd1);
    addVec("load3_issue", encI4(LOAD,4,0,4'h0), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0,
           1, encI4(LOAD,4,0,4'h0), 1, 16'hA000, 16'h0000, 16'h5A5A, 4'd1);
    addVec("enable_low", encR(SUB,1,4,4), 1,0,0, 16'h0,16'h0, 16'h0,16'h0,16'h0,
           0, encI4(LOAD,4,0,4'h0), 1, 16'hA000, 16'h0000, 16'h5A5A, 4'd1);
    addVec("stall_after_en", encR(SUB,1,4,4), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0,
           0, 16'h0000, 0, 16'hA000, 16'h0000, 16'h5A5A, 4'd2);
    addVec("jump", encI8(JUMP,3'd1,8'h23), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0,
           1, 16'h0000, 1, 16'hA000, 16'h0000, 16'h5A5A, 4'd2);
    addVec("idle", encR(ADD,1,1,1), 0,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0,
           1, 16'h0000, 0, 16'hA000, 16'h0000, 16'h5A5A, 4'd2);

    // Reset state
    clockEdge();
    clockEdge();
    checkOutput("reset.ex_ir", {16'h0, exir16}, 32'h0);
    checkOutput("reset.ex_valid", {31'h0, exv16}, 32'h0);
    checkOutput("reset.regs16", {a16, b16}, 32'h0);
    checkOutput("reset.smdr_cnt", {12'h0, s16, cnt16}, 32'h0);
    checkOutput("reset.regs32", a32 | b32 | s32, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Immediates and WB forwarding at both widths
    drive(encI8(LDIH,3,8'hA5), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0);
    clockEdge();
    checkOutput("ldih.reg_B16", {16'h0, b16}, 32'h0000A500);
    checkOutput("ldih.reg_B32", b32, 32'h0000A500);
    checkOutput("ldih.reg_A32", a32, 32'h50000303);
    drive(encI4(SLL,1,2,4'hF), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0);
    clockEdge();
    checkOutput("sll.reg_B16", {16'h0, b16}, 32'h0000000F);
    checkOutput("sll.reg_B32", b32, 32'h0000000F);
    drive(encI4(STORE,6,0,4'h0), 1,0,1, 16'h0, encR(ADD,6,0,0), 16'h0,16'h0,16'hF00D);
    wres32 = 32'hCAFEF00D;
    clockEdge();
    checkOutput("store_wb.smdr32", s32, 32'hCAFEF00D);
    checkOutput("store_wb.smdr16", {16'h0, s16}, 32'h0000F00D);
    checkOutput("store_wb.reg_A32", a32, 32'h50000000);

    // Saturating stall counter from a clean reset
    drive(16'h0, 0,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0);
    reset = 1'b1;
    clockEdge();
    checkOutput("sat.cleared", {28'h0, cnt16}, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      drive(encI4(LOAD,1,0,4'h0), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0);
      reset = 1'b0;
      clockEdge();
      drive(encR(ADD,2,1,1), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0);
      if (k == 1 || k == 20) checkOutput("sat.ready", {31'h0, ready16}, 32'h0);
      clockEdge();
      if (k == 14) checkOutput("sat.cnt14", {28'h0, cnt16}, 32'hE);
    end
    checkOutput("sat.cnt20", {28'h0, cnt16}, 32'hF);

    // Reset arriving during a load-use stall
    drive(encI4(LOAD,1,0,4'h0), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0);
    clockEdge();
    drive(encR(ADD,2,1,1), 1,0,1, 16'h0,16'h0, 16'h0,16'h0,16'h0);
    checkOutput("rst_stall.ready_before", {31'h0, ready16}, 32'h0);
    reset = 1'b1;
    clockEdge();
    checkOutput("rst_stall.ready_after", {31'h0, ready16}, 32'h1);
    checkOutput("rst_stall.ex", {15'h0, exv16, exir16}, 32'h0);
    checkOutput("rst_stall.regs", {a16, b16}, 32'h0);
    checkOutput("rst_stall.smdr_cnt", {12'h0, s16, cnt16}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
